// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp encodings, state codes and lamp decode shared by the traffic controller
package traffic_pkg;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;
  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLR_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLR_B  = 3'd5,
    FLASH  = 3'd6
  } state_t;
  function automatic logic [5:0] lamps(state_t s, logic lit);
    return s == MAIN_G ? {GREEN, RED} :
           s == MAIN_Y ? {YELLOW, RED} :
           s == SIDE_G ? {RED, GREEN} :
           s == SIDE_Y ? {RED, YELLOW} :
           s == FLASH  ? (lit ? {YELLOW, RED} : {OFF, OFF}) :
                         {RED, RED};
  endfunction
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter that advances on tick and flags expiry at zero
module dwell_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;
  // load wins over counting; the count parks at zero until the next load
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road Moore traffic-light controller with demand-driven side service and night flash
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int MAIN_MIN_TICKS = 8,
  parameter int SIDE_TICKS     = 5,
  parameter int YELLOW_TICKS   = 3,
  parameter int CLEAR_TICKS    = 2,
  parameter int FLASH_TICKS    = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       side_req,
  input  logic       flash,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] phase,
  output logic       req_pending
);
  state_t state, state_nxt;
  logic lit, lit_nxt, load, expired, fire, enter_side;
  logic [CNT_W-1:0] load_val;
  assign fire = tick && expired;
  assign enter_side = state_nxt == SIDE_G && state != SIDE_G;
  assign phase = state;
  dwell_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(CLEAR_TICKS - 1))) u_timer (
    .clock(clock),
    .reset_n(reset_n),
    .tick(tick),
    .load(load),
    .load_val(load_val),
    .expired(expired)
  );
  // next state on dwell expiry; the timer reloads on every state change and every flash half-period
  always_comb begin
    state_nxt = state;
    case (state)
      MAIN_G:  state_nxt = fire && req_pending ? MAIN_Y : MAIN_G;
      MAIN_Y:  state_nxt = fire ? CLR_A : MAIN_Y;
      CLR_A:   state_nxt = fire ? (flash ? FLASH : SIDE_G) : CLR_A;
      SIDE_G:  state_nxt = fire ? SIDE_Y : SIDE_G;
      SIDE_Y:  state_nxt = fire ? CLR_B : SIDE_Y;
      CLR_B:   state_nxt = fire ? (flash ? FLASH : MAIN_G) : CLR_B;
      FLASH:   state_nxt = fire && !flash ? CLR_B : FLASH;
      default: state_nxt = CLR_B;
    endcase
    load = state_nxt != state || (state == FLASH && fire);
    lit_nxt = state != FLASH ? 1'b1 : (fire ? ~lit : lit);
    load_val = state_nxt == MAIN_G ? CNT_W'(MAIN_MIN_TICKS - 1) :
               state_nxt == SIDE_G ? CNT_W'(SIDE_TICKS - 1) :
               state_nxt == MAIN_Y || state_nxt == SIDE_Y ? CNT_W'(YELLOW_TICKS - 1) :
               state_nxt == FLASH ? CNT_W'(FLASH_TICKS - 1) :
                                    CNT_W'(CLEAR_TICKS - 1);
  end
  // lamps are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= CLR_B;
      lit         <= 1'b1;
      req_pending <= 1'b0;
      main_light  <= RED;
      side_light  <= RED;
    end else begin
      state       <= state_nxt;
      lit         <= lit_nxt;
      req_pending <= enter_side ? 1'b0 : req_pending | side_req;
      {main_light, side_light} <= lamps(state_nxt, lit_nxt);
    end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed and randomized checks of traffic_light_ctrl against a tick-count reference model
module tb_traffic_light_ctrl;
  localparam int MAIN_MIN = 8, SIDE = 5, YEL = 3, CLR = 2, FL = 4;
  logic clock = 1'b0, reset_n = 1'b1, tick = 1'b1, side_req = 1'b0, flash = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic req_pending;
  int n_chk = 0, n_fail = 0;
  int m_ph = 5, m_e = 0;
  bit m_req = 0, m_lit = 1;

  traffic_light_ctrl dut (
    .clock(clock),
    .reset_n(reset_n),
    .tick(tick),
    .side_req(side_req),
    .flash(flash),
    .main_light(main_light),
    .side_light(side_light),
    .phase(phase),
    .req_pending(req_pending)
  );

  always #5 clock = ~clock;

  function automatic int dwell(int p);
    return p == 0 ? MAIN_MIN : (p == 1 || p == 4) ? YEL : p == 3 ? SIDE : p == 6 ? FL : CLR;
  endfunction

  function automatic logic [2:0] exp_main();
    if (m_ph == 6) return m_lit ? 3'b001 : 3'b000;
    return m_ph == 0 ? 3'b010 : m_ph == 1 ? 3'b001 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_side();
    if (m_ph == 6) return m_lit ? 3'b100 : 3'b000;
    return m_ph == 3 ? 3'b010 : m_ph == 4 ? 3'b001 : 3'b100;
  endfunction

  task automatic m_reset();
    m_ph = 5; m_e = 0; m_req = 0; m_lit = 1;
  endtask

  task automatic m_step();
    int nx;
    bit done;
    nx = m_ph;
    done = 0;
    if (tick) begin
      m_e++;
      done = m_e >= dwell(m_ph);
    end
    if (done)
      case (m_ph)
        0: nx = m_req ? 1 : 0;
        1: nx = 2;
        2: nx = flash ? 6 : 3;
        3: nx = 4;
        4: nx = 5;
        5: nx = flash ? 6 : 0;
        default: nx = flash ? 6 : 5;
      endcase
    if (done && (nx != m_ph || m_ph == 6)) m_e = 0;
    if (done && m_ph == 6 && nx == 6) m_lit = !m_lit;
    if (nx == 6 && m_ph != 6) m_lit = 1;
    m_req = (nx == 3 && m_ph != 3) ? 0 : (m_req | side_req);
    m_ph = nx;
  endtask

  task automatic check(string tag);
    n_chk++;
    assert (main_light === exp_main()) else begin n_fail++; $error("FAIL %s main_light got %b exp %b", tag, main_light, exp_main()); end
    n_chk++;
    assert (side_light === exp_side()) else begin n_fail++; $error("FAIL %s side_light got %b exp %b", tag, side_light, exp_side()); end
    n_chk++;
    assert (phase === 3'(m_ph)) else begin n_fail++; $error("FAIL %s phase got %0d exp %0d", tag, phase, m_ph); end
    n_chk++;
    assert (req_pending === m_req) else begin n_fail++; $error("FAIL %s req_pending got %b exp %b", tag, req_pending, m_req); end
    n_chk++;
    assert (phase === 3'd6 || main_light === 3'b100 || side_light === 3'b100)
      else begin n_fail++; $error("FAIL %s overlap main %b side %b exp one RED", tag, main_light, side_light); end
  endtask

  task automatic cyc(int n, string tag);
    repeat (n) begin
      if (!reset_n) m_reset(); else m_step();
      @(posedge clock);
      #1;
      check(tag);
    end
  endtask

  task automatic wait_phase(int p, int lim, string tag);
    int k = 0;
    while (phase !== 3'(p) && k < lim) begin
      cyc(1, tag);
      k++;
    end
    n_chk++;
    assert (phase === 3'(p)) else begin n_fail++; $error("FAIL %s timeout phase got %0d exp %0d", tag, phase, p); end
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1 m_reset();
    check("reset_async");
    cyc(2, "reset_hold");
    @(negedge clock);
    reset_n = 1'b1;
    cyc(2, "post_reset_clear");
    cyc(20, "main_idle");
    side_req = 1'b1;
    cyc(1, "req_pulse");
    side_req = 1'b0;
    cyc(30, "side_service");
    side_req = 1'b1;
    cyc(50, "req_held");
    side_req = 1'b0;
    for (int i = 0; i < 160; i++) begin
      tick = (i % 4 == 0);
      side_req = ($urandom % 8 == 0);
      cyc(1, "tick_div4");
    end
    tick = 1'b1;
    side_req = 1'b1;
    wait_phase(3, 80, "to_side_g");
    side_req = 1'b0;
    flash = 1'b1;
    cyc(40, "flash_on");
    flash = 1'b0;
    cyc(30, "flash_off");
    side_req = 1'b1;
    cyc(1, "req_for_yellow");
    side_req = 1'b0;
    wait_phase(1, 40, "to_main_y");
    #2 reset_n = 1'b0;
    #1 m_reset();
    check("reset_mid_yellow");
    @(negedge clock);
    reset_n = 1'b1;
    cyc(30, "restart");
    for (int i = 0; i < 600; i++) begin
      tick = ($urandom % 2 == 0);
      side_req = ($urandom % 6 == 0);
      if ($urandom % 50 == 0) flash = ~flash;
      cyc(1, "random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
